weight_stream_mem: RTL

Synthesizable, parametrised weight store that streams words to the LSTM datapath in address-ordered bursts. It replaces the fixed 8-bit, free-running behavioural weight model with a clocked block that has:
- a load port;
- a programmable start address and burst length, with wrap-around;
- two delivery modes: the legacy four-phase req/ack handshake, and a valid/ready stream that sustains one word per cycle.

It sits between the weight-load path (host/testbench) and the gate MAC units.

---
 rtl/wstream_pkg.sv | 22 ++
 rtl/wstream_ram.sv | 35 +++
 rtl/weight_stream_mem.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/wstream_pkg.sv
// Shared types and constants for the weight streaming memory.
// WSTREAM_PARITY_EN adds one even-parity bit to every stored word.
package wstream_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        HOLD,
        RELEASE,
        STREAM
    } wstate_t;

    localparam logic MODE_4PH    = 1'b0;
    localparam logic MODE_STREAM = 1'b1;

`ifdef WSTREAM_PARITY_EN
    localparam int PARITY_BITS = 1;
`else
    localparam int PARITY_BITS = 0;
`endif

endpackage

// File: rtl/wstream_ram.sv
// Single-port-write / single-port-read synchronous RAM, read-first on collision.
// Word width comes from the instantiating block (widened when WSTREAM_PARITY_EN is set).
module wstream_ram #(
    parameter int WIDTH  = 8,
    parameter int ADDR_W = 16,
    parameter int DEPTH  = 65536
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WIDTH-1:0]  rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Only the read register is reset; array contents survive rst.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/weight_stream_mem.sv
// Weight store delivering address-ordered bursts by four-phase req/ack or valid/ready.
// WSTREAM_PARITY_EN enables stored parity and the sticky par_err flag.
module weight_stream_mem
    import wstream_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 16,
    parameter int DEPTH  = 65536
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W-1:0] burst_len,
    input  logic              mode,
    input  logic              req,
    output logic              ack,
    output logic              s_valid,
    input  logic              s_ready,
    output logic [DATA_W-1:0] data,
    output logic              busy,
    output logic              done,
    output logic              par_err
);

    localparam int RAM_W = DATA_W + PARITY_BITS;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] ONE       = ADDR_W'(1);

    wstate_t           state_reg, state_next;
    logic [ADDR_W-1:0] ptr_reg, ptr_next;
    logic [ADDR_W-1:0] rem_reg, rem_next;
    logic [ADDR_W-1:0] iss_reg, iss_next;
    logic [ADDR_W-1:0] ptr_inc;
    logic              mode_reg, mode_next;
    logic              req_reg;
    logic [1:0]        occ_reg, occ_next, occ_after;
    logic              inf_reg, inf_next;
    logic              wr_idx_reg, wr_idx_next;
    logic              rd_idx_reg, rd_idx_next;
    logic              done_reg, done_next;
    logic              zero_pend_reg, zero_pend_next;
    logic              rd_en, push, pop;
    logic [RAM_W-1:0]  ram_wdata, ram_q, head;
    logic [RAM_W-1:0]  buf_q [2];

`ifdef WSTREAM_PARITY_EN
    assign ram_wdata = {^wr_data, wr_data};
`else
    assign ram_wdata = wr_data;
`endif

    wstream_ram #(
        .WIDTH  (RAM_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (ram_wdata),
        .rd_en   (rd_en),
        .rd_addr (ptr_reg),
        .rd_data (ram_q)
    );

    // Two-entry output buffer; each entry captures the read that landed last cycle.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_buf
            logic [RAM_W-1:0] entry_reg;
            always_ff @(posedge clk) begin
                if (rst) begin
                    entry_reg <= '0;
                end else if (push && (wr_idx_reg == 1'(gi))) begin
                    entry_reg <= ram_q;
                end
            end
            assign buf_q[gi] = entry_reg;
        end
    endgenerate

    assign head    = buf_q[rd_idx_reg];
    assign ptr_inc = (ptr_reg == LAST_ADDR) ? '0 : ptr_reg + ONE;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            ptr_reg       <= '0;
            rem_reg       <= '0;
            iss_reg       <= '0;
            mode_reg      <= MODE_4PH;
            req_reg       <= 1'b0;
            occ_reg       <= '0;
            inf_reg       <= 1'b0;
            wr_idx_reg    <= 1'b0;
            rd_idx_reg    <= 1'b0;
            done_reg      <= 1'b0;
            zero_pend_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            ptr_reg       <= ptr_next;
            rem_reg       <= rem_next;
            iss_reg       <= iss_next;
            mode_reg      <= mode_next;
            req_reg       <= req;
            occ_reg       <= occ_next;
            inf_reg       <= inf_next;
            wr_idx_reg    <= wr_idx_next;
            rd_idx_reg    <= rd_idx_next;
            done_reg      <= done_next;
            zero_pend_reg <= zero_pend_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        ptr_next       = ptr_reg;
        rem_next       = rem_reg;
        iss_next       = iss_reg;
        mode_next      = mode_reg;
        occ_next       = occ_reg;
        occ_after      = occ_reg;
        inf_next       = 1'b0;
        wr_idx_next    = wr_idx_reg;
        rd_idx_next    = rd_idx_reg;
        done_next      = zero_pend_reg;
        zero_pend_next = 1'b0;
        rd_en          = 1'b0;
        push           = 1'b0;
        pop            = 1'b0;

        unique case (state_reg)
            IDLE: begin
                if (start) begin
                    if (burst_len == '0) begin
                        zero_pend_next = 1'b1;
                    end else begin
                        ptr_next   = start_addr;
                        rem_next   = burst_len;
                        iss_next   = burst_len;
                        mode_next  = mode;
                        state_next = (mode == MODE_STREAM) ? STREAM : RELEASE;
                    end
                end
            end
            RELEASE: begin
                if (rem_reg == '0) begin
                    done_next  = 1'b1;
                    state_next = IDLE;
                end else if (req_reg) begin
                    state_next = FETCH;
                end
            end
            FETCH: begin
                rd_en      = 1'b1;
                ptr_next   = ptr_inc;
                rem_next   = rem_reg - ONE;
                state_next = HOLD;
            end
            HOLD: begin
                if (!req_reg) begin
                    state_next = RELEASE;
                end
            end
            STREAM: begin
                pop       = (occ_reg != 2'd0) && s_ready;
                push      = inf_reg;
                occ_after = occ_reg + {1'b0, inf_reg} - {1'b0, pop};
                // Issue only if the word can still land in the buffer next cycle.
                if ((iss_reg != '0) && (occ_after <= 2'd1)) begin
                    rd_en    = 1'b1;
                    inf_next = 1'b1;
                    iss_next = iss_reg - ONE;
                    ptr_next = ptr_inc;
                end
                occ_next = occ_after;
                if (push) begin
                    wr_idx_next = ~wr_idx_reg;
                end
                if (pop) begin
                    rd_idx_next = ~rd_idx_reg;
                    if (rem_reg != '0) begin
                        rem_next = rem_reg - ONE;
                    end
                    if (rem_reg <= ONE) begin
                        done_next  = 1'b1;
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign ack     = (state_reg == HOLD);
    assign s_valid = (state_reg == STREAM) && (occ_reg != 2'd0);
    assign data    = (mode_reg == MODE_STREAM) ? head[DATA_W-1:0] : ram_q[DATA_W-1:0];
    assign busy    = (state_reg != IDLE);
    assign done    = done_reg;

`ifdef WSTREAM_PARITY_EN
    logic par_err_reg;
    logic hold_bad, pop_bad;

    assign hold_bad = (state_reg == HOLD) && (^ram_q);
    assign pop_bad  = pop && (^head);

    always_ff @(posedge clk) begin
        if (rst) begin
            par_err_reg <= 1'b0;
        end else if (hold_bad || pop_bad) begin
            par_err_reg <= 1'b1;
        end
    end

    assign par_err = par_err_reg;
`else
    assign par_err = 1'b0;
`endif

endmodule
